// File: rtl/wb_burst_arbiter.sv
// wb_burst_arbiter
//
// Round-robin arbiter that lets three Wishbone masters (icache_0, icache_1,
// dcache) share one inner Wishbone bus. A master that wins keeps the bus for
// as long as its cyc stays high, so bursts and strobe gaps are never split.
// There is always at least one idle bus cycle between two owners.
//
// Optional feature: define WB_ARB_TIMEOUT_EN to add an 8-bit watchdog. The
// watchdog counts stalled strobe cycles. When the count reaches TIMEOUT, it
// raises m_err to the owner for one cycle and parks the arbiter in an abort
// state until the owner drops cyc. Without the macro, TIMEOUT is ignored.
//
// Ports
//   i_clk, i_rst               clock, asynchronous active-high reset
//   m_cyc/m_stb/m_we [2:0]     per-master cycle, strobe, write enable
//   m_adr [3*ADDR_W-1:0]       packed master addresses (master n in slice n)
//   m_dat_w [47:0]             packed 16-bit master write data
//   m_sel [5:0]                packed 2-bit byte selects
//   m_4_burst/m_8_burst [2:0]  per-master burst hints
//   m_ack/m_err [2:0]          per-master acknowledge / error
//   m_dat_r [15:0]             slave read data, broadcast to all masters
//   s_*                        shared inner bus (master side out, slave responses in)
//   o_grant [2:0]              one-hot current owner, zero when idle
module wb_burst_arbiter #(
   parameter int unsigned ADDR_W  = 24,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [2:0]            m_cyc,
   input  logic [2:0]            m_stb,
   input  logic [2:0]            m_we,
   input  logic [3*ADDR_W-1:0]   m_adr,
   input  logic [47:0]           m_dat_w,
   input  logic [5:0]            m_sel,
   input  logic [2:0]            m_4_burst,
   input  logic [2:0]            m_8_burst,
   output logic [2:0]            m_ack,
   output logic [2:0]            m_err,
   output logic [15:0]           m_dat_r,
   output logic                  s_cyc,
   output logic                  s_stb,
   output logic                  s_we,
   output logic [ADDR_W-1:0]     s_adr,
   output logic [15:0]           s_dat_w,
   output logic [1:0]            s_sel,
   output logic                  s_4_burst,
   output logic                  s_8_burst,
   input  logic                  s_ack,
   input  logic                  s_err,
   input  logic [15:0]           s_dat_r,
   output logic [2:0]            o_grant
);

`ifdef WB_ARB_TIMEOUT_EN
   typedef enum logic [1:0] {StIdle, StBusy, StAbort} state_e;
   localparam logic [7:0] WdLimit = 8'(TIMEOUT);
   logic [7:0] wd_q, wd_d;
`else
   typedef enum logic [0:0] {StIdle, StBusy} state_e;
`endif

   state_e     state_q, state_d;
   logic [2:0] grant_q, grant_d;
   logic [1:0] owner_q, owner_d;
   logic [1:0] last_owner_q, last_owner_d;
   logic [1:0] win_idx;
   logic       own_cyc, own_stb, busy, live, timeout_hit;

   // Index of the master 'off' positions after 'base', modulo 3.
   function automatic logic [1:0] rr_idx(input logic [1:0] base, input int unsigned off);
      int unsigned sum;
      sum = (32'(base) + off) % 3;
      return sum[1:0];
   endfunction

   // Walk the rotation backwards so the nearest successor of last_owner wins;
   // last_owner itself is the lowest priority.
   always_comb begin
      win_idx = last_owner_q;
      for (int unsigned i = 3; i >= 1; i--) begin
         if (m_cyc[rr_idx(last_owner_q, i)]) win_idx = rr_idx(last_owner_q, i);
      end
   end

   assign own_cyc = m_cyc[owner_q];
   assign own_stb = m_stb[owner_q];
   assign busy    = (state_q == StBusy);
   assign live    = busy & own_cyc;

`ifdef WB_ARB_TIMEOUT_EN
   assign timeout_hit = live & own_stb & ~s_ack & ~s_err & (wd_q == WdLimit);
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
`ifdef WB_ARB_TIMEOUT_EN
      wd_d         = wd_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (|m_cyc) begin
               grant_d = 3'b001 << win_idx;
               owner_d = win_idx;
               state_d = StBusy;
`ifdef WB_ARB_TIMEOUT_EN
               wd_d    = '0;
`endif
            end
         end
         StBusy: begin
            if (!own_cyc) begin
               state_d      = StIdle;
               grant_d      = '0;
               last_owner_d = owner_q;
            end
`ifdef WB_ARB_TIMEOUT_EN
            else if (timeout_hit) begin
               state_d = StAbort;
            end else if (s_ack || s_err) begin
               wd_d = '0;
            end else if (own_stb) begin
               wd_d = wd_q + 8'd1;
            end
`endif
         end
`ifdef WB_ARB_TIMEOUT_EN
         StAbort: begin
            if (!own_cyc) begin
               state_d      = StIdle;
               grant_d      = '0;
               last_owner_d = owner_q;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         owner_q      <= '0;
         last_owner_q <= 2'd2;
`ifdef WB_ARB_TIMEOUT_EN
         wd_q         <= '0;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
`ifdef WB_ARB_TIMEOUT_EN
         wd_q         <= wd_d;
`endif
      end
   end

   // The bus side is a pure function of the registered state, so a reset
   // blanks it in the same cycle.
   assign s_cyc     = busy & own_cyc;
   assign s_stb     = busy & own_stb;
   assign s_we      = busy & m_we[owner_q];
   assign s_adr     = busy ? m_adr[32'(owner_q)*ADDR_W +: ADDR_W] : '0;
   assign s_dat_w   = busy ? m_dat_w[32'(owner_q)*16 +: 16] : '0;
   assign s_sel     = busy ? m_sel[32'(owner_q)*2 +: 2] : '0;
   assign s_4_burst = busy & m_4_burst[owner_q];
   assign s_8_burst = busy & m_8_burst[owner_q];

   // Responses reach only the owner, and only while it still holds cyc.
   assign m_ack   = (live & s_ack) ? grant_q : '0;
   assign m_err   = ((live & s_err) | timeout_hit) ? grant_q : '0;
   assign m_dat_r = s_dat_r;
   assign o_grant = grant_q;

endmodule

// File: tb/tb_wb_burst_arbiter.sv
// Scoreboard bench for wb_burst_arbiter: the stimulus pushes expected grant
// changes and expected responses. A negedge monitor pops these entries and
// compares them whenever the DUT changes o_grant or raises ack/err.
module tb_wb_burst_arbiter;
   localparam int unsigned ADDR_W = 24;

   logic                i_clk = 1'b0;
   logic                i_rst;
   logic [2:0]          m_cyc, m_stb, m_we, m_4_burst, m_8_burst, m_ack, m_err, o_grant;
   logic [3*ADDR_W-1:0] m_adr;
   logic [47:0]         m_dat_w;
   logic [5:0]          m_sel;
   logic [15:0]         m_dat_r, s_dat_w, s_dat_r;
   logic                s_cyc, s_stb, s_we, s_4_burst, s_8_burst, s_ack, s_err;
   logic [ADDR_W-1:0]   s_adr;
   logic [1:0]          s_sel;
   logic                stall, err_inj, force_ack;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [2:0]  ack;
      logic [2:0]  err;
      logic [15:0] dat;
   } resp_t;

   logic [2:0] grant_exp_q[$];
   resp_t      resp_exp_q[$];
   logic [2:0] prev_grant = 3'b000;

   wb_burst_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(255)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_w(m_dat_w),
      .m_sel(m_sel), .m_4_burst(m_4_burst), .m_8_burst(m_8_burst),
      .m_ack(m_ack), .m_err(m_err), .m_dat_r(m_dat_r),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
      .s_sel(s_sel), .s_4_burst(s_4_burst), .s_8_burst(s_8_burst),
      .s_ack(s_ack), .s_err(s_err), .s_dat_r(s_dat_r),
      .o_grant(o_grant)
   );

   always #5 i_clk = ~i_clk;

   // Slave model: single-cycle combinational ack, read data derived from address.
   assign s_ack   = (s_cyc & s_stb & ~stall & ~err_inj) | force_ack;
   assign s_err   = s_cyc & s_stb & err_inj;
   assign s_dat_r = s_adr[15:0] ^ 16'hA5A5;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] onehot(input int k);
      return 3'(1 << k);
   endfunction

   function automatic resp_t mk_resp(input logic [2:0] a, input logic [2:0] e,
                                     input logic [23:0] adr);
      resp_t r;
      r.ack = a;
      r.err = e;
      r.dat = adr[15:0] ^ 16'hA5A5;
      return r;
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_adr(input int k, input logic [23:0] a);
      m_adr[k*ADDR_W +: ADDR_W] = a;
   endtask

   // Monitor
   always @(negedge i_clk) begin
      if (o_grant !== prev_grant) begin
         if (grant_exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL grant_unexpected: got %b, nothing expected (t=%0t)", o_grant, $time);
         end else begin
            check("grant_seq", 32'(o_grant), 32'(grant_exp_q.pop_front()));
         end
         prev_grant <= o_grant;
      end
      if ((m_ack | m_err) != 3'b000) begin
         if (resp_exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL resp_unexpected: got ack=%b err=%b, nothing expected (t=%0t)",
                     m_ack, m_err, $time);
         end else begin
            check("resp", 32'({m_ack, m_err, m_dat_r}), 32'(resp_exp_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int order [4] = '{0, 1, 2, 0};
      int k;
      int cnt;
      m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_w = '0; m_sel = '0;
      m_4_burst = '0; m_8_burst = '0;
      stall = 1'b0; err_inj = 1'b0; force_ack = 1'b0;
      i_rst = 1'b1;
      repeat (3) tick();
      check("rst_grant", 32'(o_grant), 32'd0);
      check("rst_s_cyc", 32'(s_cyc), 32'd0);
      check("rst_ack_err", 32'(m_ack | m_err), 32'd0);
      i_rst = 1'b0;
      tick();

      // Round robin with all three masters requesting
      m_cyc = 3'b111;
      for (int i = 0; i < 4; i++) begin
         k = order[i];
         grant_exp_q.push_back(onehot(k));
         tick();
         check("rr_grant", 32'(o_grant), 32'(onehot(k)));
         tick();
         m_cyc[k] = 1'b0;
         grant_exp_q.push_back(3'b000);
         tick();
         check("rr_release", 32'(o_grant), 32'd0);
         if (i < 3) m_cyc[k] = 1'b1;
         else m_cyc = 3'b000;
      end

      // dcache 4-beat write burst, icache_0 requests mid-burst
      m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_we[2] = 1'b1; m_4_burst[2] = 1'b1;
      m_sel[5:4] = 2'b11; m_dat_w[47:32] = 16'hBEEF;
      set_adr(2, 24'h000100);
      grant_exp_q.push_back(3'b100);
      resp_exp_q.push_back(mk_resp(3'b100, 3'b000, 24'h000100));
      tick();
      check("burst_s_cyc", 32'(s_cyc), 32'd1);
      check("burst_s_4", 32'(s_4_burst), 32'd1);
      check("burst_s_adr", 32'(s_adr), 32'h100);
      check("burst_s_wr", 32'({s_we, s_sel, s_dat_w}), 32'h7BEEF);
      m_cyc[0] = 1'b1;
      set_adr(0, 24'h000055);
      for (int b = 1; b < 4; b++) begin
         tick();
         set_adr(2, 24'h000100 + 24'(b));
         resp_exp_q.push_back(mk_resp(3'b100, 3'b000, 24'h000100 + 24'(b)));
      end
      tick();
      m_cyc[2] = 1'b0; m_stb[2] = 1'b0; m_we[2] = 1'b0; m_4_burst[2] = 1'b0;
      grant_exp_q.push_back(3'b000);
      grant_exp_q.push_back(3'b001);
      tick();
      check("handoff_idle", 32'(o_grant), 32'd0);
      tick();
      check("handoff_ic0", 32'(o_grant), 32'd1);
      check("ic0_no_burst", 32'(s_4_burst), 32'd0);
      m_cyc[0] = 1'b0;
      grant_exp_q.push_back(3'b000);
      tick();

      // icache_1 with an error on beat 1
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
      set_adr(1, 24'h000200);
      grant_exp_q.push_back(3'b010);
      resp_exp_q.push_back(mk_resp(3'b010, 3'b000, 24'h000200));
      tick();
      tick();
      set_adr(1, 24'h000201);
      err_inj = 1'b1;
      resp_exp_q.push_back(mk_resp(3'b000, 3'b010, 24'h000201));
      #1;
      check("err_route", 32'({m_ack, m_err}), 32'b000010);
      tick();
      err_inj = 1'b0;
      m_stb[1] = 1'b0;
      check("err_keep_grant", 32'(o_grant), 32'b010);
      tick();
      check("gap_keep_grant", 32'(o_grant), 32'b010);
      // Owner drops cyc while the slave still acks; that ack must not reach anyone.
      m_cyc[1] = 1'b0; m_stb[1] = 1'b1; force_ack = 1'b1;
      grant_exp_q.push_back(3'b000);
      #1;
      check("late_ack_dropped", 32'(m_ack), 32'd0);
      tick();
      force_ack = 1'b0; m_stb[1] = 1'b0;
      check("err_release", 32'(o_grant), 32'd0);

      // Reset in the middle of an 8-beat burst
      m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_8_burst[2] = 1'b1;
      set_adr(2, 24'h000300);
      grant_exp_q.push_back(3'b100);
      resp_exp_q.push_back(mk_resp(3'b100, 3'b000, 24'h000300));
      tick();
      check("b8_s_8", 32'(s_8_burst), 32'd1);
      for (int b = 1; b < 3; b++) begin
         tick();
         set_adr(2, 24'h000300 + 24'(b));
         resp_exp_q.push_back(mk_resp(3'b100, 3'b000, 24'h000300 + 24'(b)));
      end
      tick();
      grant_exp_q.push_back(3'b000);
      i_rst = 1'b1;
      #1;
      check("midrst_s_cyc", 32'(s_cyc), 32'd0);
      check("midrst_grant", 32'(o_grant), 32'd0);
      check("midrst_s_8", 32'(s_8_burst), 32'd0);
      check("midrst_ack", 32'(m_ack), 32'd0);
      m_cyc = 3'b101; m_stb = 3'b000; m_8_burst = 3'b000;
      tick();
      tick();
      i_rst = 1'b0;
      grant_exp_q.push_back(3'b001);
      tick();
      check("post_rst_winner", 32'(o_grant), 32'b001);
      m_cyc = 3'b000;
      grant_exp_q.push_back(3'b000);
      tick();
      check("post_rst_release", 32'(o_grant), 32'd0);

      // Stalled slave
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1; stall = 1'b1;
      set_adr(1, 24'h000400);
      grant_exp_q.push_back(3'b010);
      tick();
`ifdef WB_ARB_TIMEOUT_EN
      resp_exp_q.push_back(mk_resp(3'b000, 3'b010, 24'h000400));
      cnt = -1;
      for (int i = 0; i < 300 && cnt < 0; i++) begin
         if (m_err[1]) cnt = i;
         else tick();
      end
      check("wd_err_cycle", 32'(cnt), 32'd255);
      tick();
      check("abort_s_cyc", 32'(s_cyc), 32'd0);
      check("abort_err_pulse", 32'(m_err), 32'd0);
`else
      cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         if (s_cyc) cnt++;
         tick();
      end
      check("stall_hold", 32'(cnt), 32'd1000);
      check("stall_grant", 32'(o_grant), 32'b010);
`endif
      m_cyc = 3'b000; m_stb = 3'b000; stall = 1'b0;
      grant_exp_q.push_back(3'b000);
      tick();
      check("stall_release", 32'(o_grant), 32'd0);

      tick();
      tick();
      check("grant_q_drained", 32'(grant_exp_q.size()), 32'd0);
      check("resp_q_drained", 32'(resp_exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
